bp_btb_bht: RTL and testbench

Parametrised branch predictor for the five-stage RV32I pipeline: a direct-mapped branch target buffer with per-entry saturating counters, queried combinationally with the IF-stage PC and trained from the EX stage. Predictions travel down an internal IF→ID→EX shadow pipeline that obeys the hazard unit's bubble/flush controls, so the block itself flags mispredictions and supplies the corrected PC. It succeeds the single-bit taken/not-taken predictor with configurable depth and counter width, full tags and target-mismatch detection.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_pred_pipe.sv | 33 +++
 rtl/bp_btb_bht.sv | 135 +++++++++++++
 tb/tb_bp_btb_bht.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB/BHT branch predictor.
// Counters are handled at a fixed maximum width here and narrowed to
// CTR_BITS by the predictor, so the helpers serve every configuration.
package bp_pkg;

   localparam int CTR_MAX_BITS = 4;

   typedef logic [CTR_MAX_BITS-1:0] ctr_t;

   // Counter value after reset: strongly not taken.
   localparam ctr_t CTR_RST = '0;

   // Largest counter value for a given counter width.
   function automatic ctr_t ctr_max(input int bits);
      return ctr_t'((1 << bits) - 1);
   endfunction

   // Weakly-taken value loaded on allocation: MSB set, rest clear.
   function automatic ctr_t ctr_weak(input int bits);
      return ctr_t'(1 << (bits - 1));
   endfunction

   // Saturating increment at the top of the counter range.
   function automatic ctr_t sat_inc(input ctr_t c, input int bits);
      return (c == ctr_max(bits)) ? c : c + ctr_t'(1);
   endfunction

   // Saturating decrement at zero.
   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == CTR_RST) ? c : c - ctr_t'(1);
   endfunction

endpackage

// File: rtl/bp_pred_pipe.sv
// One stage of the prediction shadow pipeline: holds {taken, target}
// for the instruction in that stage, following the hazard unit controls.
module bp_pred_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bubble,
   input  logic            flush,
   input  logic            taken_in,
   input  logic [XLEN-1:0] target_in,
   output logic            taken_out,
   output logic [XLEN-1:0] target_out
);

   // Bubble holds the stage and wins over flush; flush inserts an empty slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taken_out  <= 1'b0;
         target_out <= '0;
      end else if (bubble) begin
         taken_out  <= taken_out;
         target_out <= target_out;
      end else if (flush) begin
         taken_out  <= 1'b0;
         target_out <= '0;
      end else begin
         taken_out  <= taken_in;
         target_out <= target_in;
      end
   end

endmodule

// File: rtl/bp_btb_bht.sv
// Direct-mapped BTB with per-entry saturating counters. Queried
// combinationally from IF, trained from EX; predictions ride a D/E shadow
// pipeline so misprediction and the corrected PC are produced here.
// Optional: define BP_STATS_EN to add branch / mispredict counters.
module bp_btb_bht
   import bp_pkg::*;
#(
   parameter int ENTRIES  = 64,
   parameter int CTR_BITS = 2,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_query,
   output logic            pred_taken,
   output logic [XLEN-1:0] npc_pred,
   input  logic            bubble_d,
   input  logic            flush_d,
   input  logic            bubble_e,
   input  logic            flush_e,
   input  logic            update,
   input  logic [XLEN-1:0] pc_update,
   input  logic [XLEN-1:0] target_update,
   input  logic            taken_actual,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IW = $clog2(ENTRIES);
   localparam int TW = XLEN - IW - 2;

   typedef struct packed {
      logic                valid;
      logic [TW-1:0]       tag;
      logic [XLEN-1:0]     target;
      logic [CTR_BITS-1:0] ctr;
   } entry_t;

   entry_t tbl [ENTRIES];

   logic [IW-1:0]       q_idx, u_idx;
   logic [TW-1:0]       q_tag, u_tag;
   logic                q_hit, u_hit;
   logic                pred_if;
   logic [XLEN-1:0]     q_target;
   logic [CTR_BITS-1:0] ctr_up, ctr_dn, ctr_alloc;
   logic                d_taken, e_taken;
   logic [XLEN-1:0]     d_target, e_target;
   logic                mis_raw;

   assign q_idx = pc_query[IW+1:2];
   assign q_tag = pc_query[XLEN-1:IW+2];
   assign u_idx = pc_update[IW+1:2];
   assign u_tag = pc_update[XLEN-1:IW+2];

   // The table is read before the edge, so a same-cycle write is not seen.
   assign q_hit    = tbl[q_idx].valid && (tbl[q_idx].tag == q_tag);
   assign u_hit    = tbl[u_idx].valid && (tbl[u_idx].tag == u_tag);
   assign q_target = tbl[q_idx].target;

   assign pred_if    = rst && q_hit && tbl[q_idx].ctr[CTR_BITS-1];
   assign pred_taken = pred_if;
   assign npc_pred   = pred_if ? q_target : pc_query + XLEN'(4);

   assign ctr_up    = CTR_BITS'(sat_inc(ctr_t'(tbl[u_idx].ctr), CTR_BITS));
   assign ctr_dn    = CTR_BITS'(sat_dec(ctr_t'(tbl[u_idx].ctr)));
   assign ctr_alloc = CTR_BITS'(ctr_weak(CTR_BITS));

   // Training: adjust on hit, allocate weakly-taken on a taken miss.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
      end else if (update) begin
         if (u_hit) begin
            tbl[u_idx].ctr <= taken_actual ? ctr_up : ctr_dn;
            if (taken_actual) tbl[u_idx].target <= target_update;
         end else if (taken_actual) begin
            tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: target_update, ctr: ctr_alloc};
         end
      end
   end

   bp_pred_pipe #(.XLEN(XLEN)) u_pipe_d (
      .clk       (clk),
      .rst       (rst),
      .bubble    (bubble_d),
      .flush     (flush_d),
      .taken_in  (pred_if),
      .target_in (q_target),
      .taken_out (d_taken),
      .target_out(d_target)
   );

   bp_pred_pipe #(.XLEN(XLEN)) u_pipe_e (
      .clk       (clk),
      .rst       (rst),
      .bubble    (bubble_e),
      .flush     (flush_e),
      .taken_in  (d_taken),
      .target_in (d_target),
      .taken_out (e_taken),
      .target_out(e_target)
   );

   // Wrong direction, wrong target, or a taken prediction on a non-branch.
   always_comb begin
      mis_raw = e_taken;
      if (update)
         mis_raw = (e_taken != taken_actual) ||
                   (e_taken && taken_actual && (e_target != target_update));
   end

   assign mispredict  = rst && mis_raw;
   assign redirect_pc = (rst && update && taken_actual) ? target_update
                                                        : pc_update + XLEN'(4);

`ifdef BP_STATS_EN
   // Event counters; a stalled EX stage is not counted again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (!bubble_e) begin
         if (update)     stat_branches    <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bp_btb_bht.sv
// Bench for bp_btb_bht: directed table, hand sequences for pipeline
// controls and reset, then random traffic against a behavioural model.
module tb_bp_btb_bht;

   localparam int ENTRIES = 4;
   localparam int CB      = 2;
   localparam int XLEN    = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_query, npc_pred, pc_update, target_update, redirect_pc;
   logic        pred_taken, bubble_d, flush_d, bubble_e, flush_e;
   logic        update, taken_actual, mispredict;
`ifdef BP_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bp_btb_bht #(.ENTRIES(ENTRIES), .CTR_BITS(CB), .XLEN(XLEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_query     (pc_query),
      .pred_taken   (pred_taken),
      .npc_pred     (npc_pred),
      .bubble_d     (bubble_d),
      .flush_d      (flush_d),
      .bubble_e     (bubble_e),
      .flush_e      (flush_e),
      .update       (update),
      .pc_update    (pc_update),
      .target_update(target_update),
      .taken_actual (taken_actual),
      .mispredict   (mispredict),
      .redirect_pc  (redirect_pc)
`ifdef BP_STATS_EN
      ,
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   typedef struct {
      logic [31:0] pcq;
      logic        upd;
      logic [31:0] pcu;
      logic [31:0] tgtu;
      logic        tk, bd, fd, be, fe;
      logic        pt;
      logic [31:0] npc;
      logic        mis;
      logic [31:0] red;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(input logic [31:0] pcq, input logic upd, input logic [31:0] pcu,
                              input logic [31:0] tgtu, input logic tk, input logic bd, input logic fd,
                              input logic be, input logic fe, input logic pt, input logic [31:0] npc,
                              input logic mis, input logic [31:0] red);
      vec_t r;
      r = '{pcq, upd, pcu, tgtu, tk, bd, fd, be, fe, pt, npc, mis, red};
      return r;
   endfunction

   // Behavioural model: each slot remembers which branch (by word address) lives there.
   logic        m_vld  [ENTRIES];
   logic [31:0] m_word [ENTRIES];
   logic [31:0] m_tgt  [ENTRIES];
   int          m_ctr  [ENTRIES];
   logic        md_t, me_t;
   logic [31:0] md_tgt, me_tgt;

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_vld[i] = 1'b0; m_word[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
      end
      md_t = 1'b0; me_t = 1'b0; md_tgt = '0; me_tgt = '0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check just after, model advances with the edge.
   task automatic cyc(input string nm, input vec_t x, input bit use_model, input logic r);
      int          qs, us;
      logic        hit, pt, mis, uhit;
      logic [31:0] npc, red, ptgt;
      @(negedge clk);
      rst = r;
      pc_query = x.pcq; update = x.upd; pc_update = x.pcu; target_update = x.tgtu;
      taken_actual = x.tk; bubble_d = x.bd; flush_d = x.fd; bubble_e = x.be; flush_e = x.fe;
      #1;
      qs   = int'((x.pcq >> 2) % ENTRIES);
      hit  = m_vld[qs] && (m_word[qs] == (x.pcq >> 2));
      pt   = r && hit && (m_ctr[qs] >= (1 << (CB - 1)));
      ptgt = pt ? m_tgt[qs] : 32'h0;
      npc  = pt ? m_tgt[qs] : x.pcq + 32'd4;
      if (!r)         mis = 1'b0;
      else if (x.upd) mis = (me_t != x.tk) || (me_t && x.tk && (me_tgt != x.tgtu));
      else            mis = me_t;
      red  = (r && x.upd && x.tk) ? x.tgtu : x.pcu + 32'd4;
      if (use_model) begin
         chk({nm, " pred_taken"},  {31'b0, pred_taken}, {31'b0, pt});
         chk({nm, " npc_pred"},    npc_pred,             npc);
         chk({nm, " mispredict"},  {31'b0, mispredict}, {31'b0, mis});
         chk({nm, " redirect_pc"}, redirect_pc,          red);
      end else begin
         chk({nm, " pred_taken"},  {31'b0, pred_taken}, {31'b0, x.pt});
         chk({nm, " npc_pred"},    npc_pred,             x.npc);
         chk({nm, " mispredict"},  {31'b0, mispredict}, {31'b0, x.mis});
         chk({nm, " redirect_pc"}, redirect_pc,          x.red);
      end
      if (!r) begin
         model_reset();
      end else begin
         if (!x.be) begin
            if (x.fe) begin me_t = 1'b0; me_tgt = '0; end
            else      begin me_t = md_t; me_tgt = md_tgt; end
         end
         if (!x.bd) begin
            if (x.fd) begin md_t = 1'b0; md_tgt = '0; end
            else      begin md_t = pt;   md_tgt = ptgt; end
         end
         if (x.upd) begin
            us   = int'((x.pcu >> 2) % ENTRIES);
            uhit = m_vld[us] && (m_word[us] == (x.pcu >> 2));
            if (uhit) begin
               if (x.tk) begin
                  if (m_ctr[us] < (1 << CB) - 1) m_ctr[us]++;
                  m_tgt[us] = x.tgtu;
               end else if (m_ctr[us] > 0) begin
                  m_ctr[us]--;
               end
            end else if (x.tk) begin
               m_vld[us] = 1'b1; m_word[us] = x.pcu >> 2; m_tgt[us] = x.tgtu;
               m_ctr[us] = 1 << (CB - 1);
            end
         end
      end
      @(posedge clk);
   endtask

   initial begin
      vec_t rv;
      rst = 1'b0;
      pc_query = 32'h100; update = 1'b1; pc_update = 32'h20; target_update = 32'h40;
      taken_actual = 1'b1; bubble_d = 1'b0; flush_d = 1'b0; bubble_e = 1'b0; flush_e = 1'b0;
      model_reset();

      // Directed rows: ENTRIES=4, so 0x100/0x110/0x80 share slot 0.
      //          pcq           upd pcu           tgtu        tk bd fd be fe  pt npc           mis red
      tv.push_back(v(32'h100,      0, 32'h0,        32'h0,   0, 0,0,0,0, 0, 32'h104,      0, 32'h4));
      tv.push_back(v(32'h104,      0, 32'h0,        32'h0,   0, 0,0,0,0, 0, 32'h108,      0, 32'h4));
      tv.push_back(v(32'h108,      1, 32'h100,      32'h80,  1, 0,0,0,0, 0, 32'h10C,      1, 32'h80));
      tv.push_back(v(32'h100,      0, 32'h0,        32'h0,   0, 0,0,0,0, 1, 32'h80,       0, 32'h4));
      tv.push_back(v(32'h80,       0, 32'h0,        32'h0,   0, 0,0,0,0, 0, 32'h84,       0, 32'h4));
      tv.push_back(v(32'h84,       1, 32'h100,      32'h80,  1, 0,0,0,0, 0, 32'h88,       0, 32'h80));
      tv.push_back(v(32'h104,      1, 32'h100,      32'h80,  1, 0,0,0,0, 0, 32'h108,      1, 32'h80));
      tv.push_back(v(32'h104,      1, 32'h100,      32'h80,  1, 0,0,0,0, 0, 32'h108,      1, 32'h80));
      tv.push_back(v(32'h104,      1, 32'h100,      32'h80,  1, 0,0,0,0, 0, 32'h108,      1, 32'h80));
      tv.push_back(v(32'h100,      0, 32'h0,        32'h0,   0, 0,0,0,0, 1, 32'h80,       0, 32'h4));
      tv.push_back(v(32'h104,      1, 32'h100,      32'h80,  0, 0,0,0,0, 0, 32'h108,      0, 32'h104));
      tv.push_back(v(32'h104,      1, 32'h100,      32'h80,  0, 0,0,0,0, 0, 32'h108,      1, 32'h104));
      tv.push_back(v(32'h100,      0, 32'h0,        32'h0,   0, 0,0,0,0, 0, 32'h104,      0, 32'h4));
      tv.push_back(v(32'h104,      1, 32'h100,      32'h80,  1, 0,0,0,0, 0, 32'h108,      1, 32'h80));
      tv.push_back(v(32'h104,      1, 32'h100,      32'h80,  1, 0,0,0,0, 0, 32'h108,      1, 32'h80));
      tv.push_back(v(32'h100,      0, 32'h0,        32'h0,   0, 0,0,0,0, 1, 32'h80,       0, 32'h4));
      tv.push_back(v(32'h104,      0, 32'h0,        32'h0,   0, 0,0,0,0, 0, 32'h108,      0, 32'h4));
      tv.push_back(v(32'h104,      1, 32'h100,      32'hC0,  1, 0,0,0,0, 0, 32'h108,      1, 32'hC0));
      tv.push_back(v(32'h100,      0, 32'h0,        32'h0,   0, 0,0,0,0, 1, 32'hC0,       0, 32'h4));
      tv.push_back(v(32'h104,      1, 32'h110,      32'h200, 1, 0,0,0,0, 0, 32'h108,      1, 32'h200));
      tv.push_back(v(32'h100,      0, 32'h0,        32'h0,   0, 0,0,0,0, 0, 32'h104,      1, 32'h4));
      tv.push_back(v(32'h110,      0, 32'h0,        32'h0,   0, 0,0,0,0, 1, 32'h200,      0, 32'h4));
      tv.push_back(v(32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h0,   0, 0,0,0,0, 0, 32'h0,        0, 32'h0));
      tv.push_back(v(32'h104,      1, 32'h104,      32'h40,  0, 0,0,0,0, 0, 32'h108,      1, 32'h108));
      tv.push_back(v(32'h104,      0, 32'h0,        32'h0,   0, 0,0,0,0, 0, 32'h108,      0, 32'h4));

      // Reset state: outputs forced to their idle values even with a branch resolving.
      #2;
      chk("reset pred_taken",  {31'b0, pred_taken}, 32'd0);
      chk("reset npc_pred",    npc_pred,             32'h104);
      chk("reset mispredict",  {31'b0, mispredict}, 32'd0);
      chk("reset redirect_pc", redirect_pc,          32'h24);
      cyc("reset0", v(32'h100, 1, 32'h20, 32'h40, 1, 0,0,0,0, 0,32'h0,0,32'h0), 1'b1, 1'b0);

      foreach (tv[i]) cyc($sformatf("row%0d", i), tv[i], 1'b0, 1'b1);

      // Shadow pipeline: bubble beats flush in D, a stalled E holds, flush_e clears E.
      cyc("h0", v(32'h110, 0, 32'h0,   32'h0,   0, 0,0,0,0, 1, 32'h200, 0, 32'h4),   1'b0, 1'b1);
      cyc("h1", v(32'h104, 0, 32'h0,   32'h0,   0, 1,1,1,0, 0, 32'h108, 0, 32'h4),   1'b0, 1'b1);
      cyc("h2", v(32'h104, 0, 32'h0,   32'h0,   0, 1,1,1,0, 0, 32'h108, 0, 32'h4),   1'b0, 1'b1);
      cyc("h3", v(32'h104, 0, 32'h0,   32'h0,   0, 1,1,1,0, 0, 32'h108, 0, 32'h4),   1'b0, 1'b1);
      cyc("h4", v(32'h104, 0, 32'h0,   32'h0,   0, 0,0,0,0, 0, 32'h108, 0, 32'h4),   1'b0, 1'b1);
      cyc("h5", v(32'h110, 0, 32'h0,   32'h0,   0, 0,0,0,0, 1, 32'h200, 1, 32'h4),   1'b0, 1'b1);
      cyc("h6", v(32'h104, 0, 32'h0,   32'h0,   0, 1,0,0,1, 0, 32'h108, 0, 32'h4),   1'b0, 1'b1);
      cyc("h7", v(32'h104, 0, 32'h0,   32'h0,   0, 0,0,0,0, 0, 32'h108, 0, 32'h4),   1'b0, 1'b1);
      cyc("h8", v(32'h104, 1, 32'h110, 32'h200, 1, 0,0,0,0, 0, 32'h108, 0, 32'h200), 1'b0, 1'b1);

      // Random traffic, a small PC pool so slots alias and counters move.
      for (int n = 0; n < 600; n++) begin
         rv.pcq  = ($urandom_range(0, 31) == 0) ? 32'hFFFFFFFC : 32'h100 + 32'($urandom_range(0, 15)) * 4;
         rv.upd  = 1'($urandom_range(0, 1));
         rv.pcu  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
         rv.tgtu = ($urandom_range(0, 3) == 0) ? $urandom : 32'h40 * 32'($urandom_range(1, 4));
         rv.tk   = 1'($urandom_range(0, 1));
         rv.bd   = ($urandom_range(0, 6) == 0);
         rv.fd   = ($urandom_range(0, 6) == 0);
         rv.be   = ($urandom_range(0, 6) == 0);
         rv.fe   = ($urandom_range(0, 6) == 0);
         rv.pt = 1'b0; rv.npc = '0; rv.mis = 1'b0; rv.red = '0;
         cyc($sformatf("rand%0d", n), rv, 1'b1, 1'b1);
      end

      // Make slot 0 predict taken, then reset during a training cycle.
      cyc("pre0", v(32'h104, 1, 32'h110, 32'h200, 1, 0,0,0,0, 0,32'h0,0,32'h0), 1'b1, 1'b1);
      cyc("pre1", v(32'h104, 1, 32'h110, 32'h200, 1, 0,0,0,0, 0,32'h0,0,32'h0), 1'b1, 1'b1);
      cyc("pre2", v(32'h110, 0, 32'h0,   32'h0,   0, 0,0,0,0, 0,32'h0,0,32'h0), 1'b1, 1'b1);
      @(negedge clk);
      pc_query = 32'h110; update = 1'b1; pc_update = 32'h300; target_update = 32'h40;
      taken_actual = 1'b1; bubble_d = 1'b0; flush_d = 1'b0; bubble_e = 1'b0; flush_e = 1'b0;
      #1 chk("midreset hit before", {31'b0, pred_taken}, 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("midreset pred_taken",  {31'b0, pred_taken}, 32'd0);
      chk("midreset npc_pred",    npc_pred,             32'h114);
      chk("midreset mispredict",  {31'b0, mispredict}, 32'd0);
      chk("midreset redirect_pc", redirect_pc,          32'h304);
      model_reset();
      cyc("post0", v(32'h300, 0, 32'h0, 32'h0, 0, 0,0,0,0, 0, 32'h304, 0, 32'h4), 1'b0, 1'b1);
      cyc("post1", v(32'h110, 0, 32'h0, 32'h0, 0, 0,0,0,0, 0, 32'h114, 0, 32'h4), 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
